// File: rtl/disp_scan_ctrl.sv
// Four-digit common-anode seven-segment scanner with frame-aligned
// double-buffered value/dp/blank registers and registered decode.
module disp_scan_ctrl #(
    parameter int TICK_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        E,
    input  logic        load,
    input  logic [15:0] value,
    input  logic [3:0]  dp,
    input  logic [3:0]  blank,
    output logic [3:0]  AN,
    output logic [7:0]  SEGMENT,
    output logic [1:0]  scan,
    output logic        frame_done
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    scan_q, scan_d;
    logic          frame_done_q, frame_done_d;
    logic [15:0]   act_val_q, act_val_d;
    logic [3:0]    act_dp_q, act_dp_d;
    logic [3:0]    act_bl_q, act_bl_d;
    logic [15:0]   pnd_val_q, pnd_val_d;
    logic [3:0]    pnd_dp_q, pnd_dp_d;
    logic [3:0]    pnd_bl_q, pnd_bl_d;
    logic          pend_q, pend_d;
    logic [3:0]    an_q, an_d;
    logic [7:0]    seg_q, seg_d;

    logic       tick;
    logic       wrap;
    logic       commit;
    logic       lit;
    logic [3:0] digit;

    function automatic logic [6:0] hex7(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    always_comb begin
        tick = E && (presc_q == PMAX);
        wrap = tick && (scan_q == 2'd3);

        presc_d = (!E || tick) ? '0 : presc_q + 1'b1;
        scan_d  = !E ? 2'd0 : (tick ? scan_q + 2'd1 : scan_q);
        frame_done_d = wrap;

        // Commit sees the old pending copy even if load arrives this cycle.
        commit   = pend_q && (wrap || !E);
        act_val_d = commit ? pnd_val_q : act_val_q;
        act_dp_d  = commit ? pnd_dp_q  : act_dp_q;
        act_bl_d  = commit ? pnd_bl_q  : act_bl_q;

        pnd_val_d = load ? value : pnd_val_q;
        pnd_dp_d  = load ? dp    : pnd_dp_q;
        pnd_bl_d  = load ? blank : pnd_bl_q;
        pend_d    = load ? 1'b1 : (commit ? 1'b0 : pend_q);

        digit = act_val_q[{scan_q, 2'b00} +: 4];
        lit   = E && !act_bl_q[scan_q];
        an_d  = lit ? ~(4'b0001 << scan_q) : 4'hF;
        seg_d = lit ? {~act_dp_q[scan_q], hex7(digit)} : 8'hFF;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q      <= '0;
            scan_q       <= 2'd0;
            frame_done_q <= 1'b0;
            act_val_q    <= 16'h0;
            act_dp_q     <= 4'h0;
            act_bl_q     <= 4'h0;
            pnd_val_q    <= 16'h0;
            pnd_dp_q     <= 4'h0;
            pnd_bl_q     <= 4'h0;
            pend_q       <= 1'b0;
            an_q         <= 4'hF;
            seg_q        <= 8'hFF;
        end else begin
            presc_q      <= presc_d;
            scan_q       <= scan_d;
            frame_done_q <= frame_done_d;
            act_val_q    <= act_val_d;
            act_dp_q     <= act_dp_d;
            act_bl_q     <= act_bl_d;
            pnd_val_q    <= pnd_val_d;
            pnd_dp_q     <= pnd_dp_d;
            pnd_bl_q     <= pnd_bl_d;
            pend_q       <= pend_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
        end
    end

    assign AN         = an_q;
    assign SEGMENT    = seg_q;
    assign scan       = scan_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Bench for disp_scan_ctrl: directed scenarios plus random traffic,
// all compared every cycle against an arithmetic frame-time model.
module tb_disp_scan_ctrl;

    localparam int TD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        E = 1'b1;
    logic        load = 1'b0;
    logic [15:0] value = 16'h0;
    logic [3:0]  dp = 4'h0;
    logic [3:0]  blank = 4'h0;
    logic [3:0]  AN;
    logic [7:0]  SEGMENT;
    logic [1:0]  scan;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    logic [7:0] hex_tab [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    // Model: enabled-cycle count since last disable/reset fixes slot and frame.
    int          m_cnt = 0;
    logic [15:0] m_av = 0, m_pv = 0;
    logic [3:0]  m_ad = 0, m_ab = 0, m_pd = 0, m_pb = 0;
    logic        m_pend = 0;
    logic [3:0]  e_an = 4'hF;
    logic [7:0]  e_seg = 8'hFF;
    logic [1:0]  e_scan = 0;
    logic        e_fd = 0;

    disp_scan_ctrl #(.TICK_DIV(TD)) dut (
        .clk(clk), .rst(rst), .E(E), .load(load),
        .value(value), .dp(dp), .blank(blank),
        .AN(AN), .SEGMENT(SEGMENT), .scan(scan),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic model_step();
        int d;
        int nxt;
        logic [7:0] h;
        if (rst) begin
            m_cnt = 0;
            m_av = 0; m_ad = 0; m_ab = 0;
            m_pv = 0; m_pd = 0; m_pb = 0;
            m_pend = 0;
            e_an = 4'hF; e_seg = 8'hFF; e_scan = 0; e_fd = 0;
        end else begin
            d = (m_cnt / TD) % 4;
            h = hex_tab[4'((m_av >> (4 * d)) & 16'hF)];
            if (E && !m_ab[d]) begin
                e_an = 4'hF ^ (4'h1 << d);
                e_seg = {~m_ad[d], h[6:0]};
            end else begin
                e_an = 4'hF;
                e_seg = 8'hFF;
            end
            nxt = E ? m_cnt + 1 : 0;
            if (m_pend && (!E || (nxt % (4 * TD) == 0))) begin
                m_av = m_pv; m_ad = m_pd; m_ab = m_pb;
                m_pend = 0;
            end
            if (load) begin
                m_pv = value; m_pd = dp; m_pb = blank;
                m_pend = 1;
            end
            e_fd = E && (nxt % (4 * TD) == 0);
            m_cnt = nxt;
            e_scan = 2'((m_cnt / TD) % 4);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        chk("an", {12'h0, AN}, {12'h0, e_an});
        chk("seg", {8'h0, SEGMENT}, {8'h0, e_seg});
        chk("scan", {14'h0, scan}, {14'h0, e_scan});
        chk("fd", {15'h0, frame_done}, {15'h0, e_fd});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic ld(input logic [15:0] v, input logic [3:0] p,
                      input logic [3:0] b);
        load = 1; value = v; dp = p; blank = b;
        cyc();
        load = 0;
    endtask

    initial begin
        logic [7:0] t2_seg [4];
        t2_seg[0] = 8'h80; t2_seg[1] = 8'hC0;
        t2_seg[2] = 8'hA4; t2_seg[3] = 8'hF9;

        // Reset dominates enable and load.
        rst = 1; E = 1; load = 1; value = 16'hABCD;
        run(2);
        chk("rst_an", {12'h0, AN}, 16'hF);
        chk("rst_seg", {8'h0, SEGMENT}, 16'hFF);
        chk("rst_scan", {14'h0, scan}, 16'h0);
        chk("rst_fd", {15'h0, frame_done}, 16'h0);
        rst = 0; load = 0;
        cyc();
        chk("first_an", {12'h0, AN}, 16'hE);
        chk("first_seg", {8'h0, SEGMENT}, 16'hC0);

        // Scan order with load while disabled.
        E = 0;
        cyc();
        ld(16'h1208, 4'h0, 4'h0);
        run(2);
        E = 1;
        for (int i = 0; i < 16; i++) begin
            cyc();
            chk("t2_an", {12'h0, AN}, {12'h0, 4'hF ^ (4'h1 << (i / 4))});
            chk("t2_seg", {8'h0, SEGMENT}, {8'h0, t2_seg[i / 4]});
            chk("t2_fd", {15'h0, frame_done}, {15'h0, i == 15});
        end

        // Mid-frame load, then load on the commit cycle itself.
        run(4);
        ld(16'hFFFF, 4'h0, 4'h0);
        run(11);
        chk("t3_old_an", {12'h0, AN}, 16'h7);
        chk("t3_old_seg", {8'h0, SEGMENT}, 16'hF9);
        run(1);
        chk("t3_new_seg", {8'h0, SEGMENT}, 16'h8E);
        run(7);
        ld(16'h3333, 4'h0, 4'h0);
        run(6);
        ld(16'h5555, 4'h0, 4'h0);
        chk("t3_edge_seg", {8'h0, SEGMENT}, 16'h8E);
        run(1);
        chk("t3_older_seg", {8'h0, SEGMENT}, 16'hB0);
        run(16);
        chk("t3_newer_seg", {8'h0, SEGMENT}, 16'h92);

        // Blank and decimal point.
        ld(16'h1208, 4'b0001, 4'b0100);
        run(14);
        run(1);
        chk("t4_d0_an", {12'h0, AN}, 16'hE);
        chk("t4_d0_seg", {8'h0, SEGMENT}, 16'h00);
        run(8);
        chk("t4_d2_an", {12'h0, AN}, 16'hF);
        chk("t4_d2_seg", {8'h0, SEGMENT}, 16'hFF);
        run(4);
        chk("t4_d3_an", {12'h0, AN}, 16'h7);

        // Enable drop at digit 2, then full first slot on re-enable.
        run(11);
        chk("t5_pre_scan", {14'h0, scan}, 16'h2);
        E = 0;
        cyc();
        chk("t5_off_an", {12'h0, AN}, 16'hF);
        chk("t5_off_seg", {8'h0, SEGMENT}, 16'hFF);
        E = 1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("t5_slot_an", {12'h0, AN}, 16'hE);
        end
        cyc();
        chk("t5_next_an", {12'h0, AN}, 16'hD);

        // Reset with a pending load discards it.
        ld(16'h7777, 4'h0, 4'h0);
        run(6);
        chk("t6_pre_scan", {14'h0, scan}, 16'h3);
        rst = 1;
        cyc();
        chk("t6_rst_an", {12'h0, AN}, 16'hF);
        chk("t6_rst_seg", {8'h0, SEGMENT}, 16'hFF);
        rst = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            chk("t6_seg", {8'h0, SEGMENT}, 16'hC0);
        end

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            E = ($urandom_range(0, 15) != 0);
            load = ($urandom_range(0, 9) == 0);
            value = 16'($urandom);
            dp = 4'($urandom);
            blank = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
